hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline.
//  Keeps its own scoreboard of in-flight destinations, so the top level no longer rebuilds dest/WB_En taps per stage.
//  Sits beside ID: resolves both ID operands to regfile / forwarded value, or stalls IF/ID.
//  Covers multi-cycle load latency and variable pipeline depth, which the fixed per-stage equations did not.
// PARAMETERS
//  REG_ADDR_W  5   register index width; index 0 is hard-wired zero, never a hazard
//  DATA_W      32  operand / result width
//  FWD_DEPTH   3   tracked entries past ID: 0=EX, 1=EXE/MEM reg, ..., FWD_DEPTH-1=last stage before regfile write
//  LOAD_STAGE  2   first entry index at which load data is valid on stage_data; 1 <= LOAD_STAGE <= FWD_DEPTH-1
//  CNT_W       16  width of performance counters
// PORTS
//  clk         in   1                    rising-edge clock
//  rst         in   1                    asynchronous, active-low reset
//  id_valid    in   1                    instruction present in ID
//  id_src1     in   REG_ADDR_W           source 1 index
//  id_src2     in   REG_ADDR_W           source 2 index
//  id_use_src2 in   1                    src2 is read (R-type, store, BNE); 0 for immediate forms
//  id_dest     in   REG_ADDR_W           destination index
//  id_wb_en    in   1                    instruction writes a register
//  id_mem_r_en in   1                    instruction is a load
//  flush       in   1                    branch taken: ID instruction is killed this cycle
//  ex_result   in   DATA_W               combinational ALU result of entry 0
//  stage_data  in   (FWD_DEPTH-1)*DATA_W result of entry k held in slice k-1 (ALU result or load data)
//  id_stall    out  1                    hold PC and IF/ID; ID/EX receives bubble
//  fwd1_en     out  1                    use fwd1_data instead of regfile port 1
//  fwd1_data   out  DATA_W               forwarded src1 value
//  fwd2_en     out  1                    use fwd2_data instead of regfile port 2
//  fwd2_data   out  DATA_W               forwarded src2 value
//  stall_cnt   out  CNT_W                cycles with id_stall=1, saturating
//  fwd_cnt     out  CNT_W                cycles with fwd1_en|fwd2_en, saturating
// BEHAVIOUR
//  - Scoreboard: FWD_DEPTH entries {valid, dest, wb_en, is_load}; advances every cycle, since stages past ID never stall.
//    Entry 0 <= ID instruction if id_valid & ~id_stall & ~flush, else bubble (valid=0). Entry k <= entry k-1. The last entry retires.
//  - Match(s,k) = entry k valid & wb_en & dest==s & s!=0. Used for src1 always; for src2 only when id_use_src2.
//  - Youngest match wins (lowest k). Older matches for the same source are ignored.
//  - Data ready at k: non-load -> always (k=0 uses ex_result, k>=1 uses stage_data slice k-1); load -> k>=LOAD_STAGE.
//  - id_stall = id_valid & ~flush & (youngest match on any used source not ready). Combinational, same cycle.
//  - fwdN_en = id_valid & youngest match ready; fwdN_data = that entry's value, else 0.
//  - The regfile is not write-through: the last entry must be forwarded, never left to the regfile.
//  - flush with a hazard: flush wins; id_stall=0 and a bubble is inserted.
//  - Load-use, LOAD_STAGE=2: load at k=0 -> stall; next cycle k=1 -> stall; then k=2 -> forward. Two stall cycles.
//  - Counters: +1 per qualifying cycle, hold at 2^CNT_W-1.
//  - Reset (async, rst=0): all entries invalid, counters 0.
//    Combinational outputs are therefore 0, except id_stall cannot assert because no entry matches.
//    Reset mid-operation drops all in-flight hazards immediately.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: behaviour as above.
//  Not defined: fwd1_en=fwd2_en=0, fwd_cnt stays 0, and any match at any k stalls.
//  In that mode a dependent instruction waits until the producer retires from the last entry.
// STRUCTURE
//  Package hazard_pkg: sb_entry_t struct {valid, dest, wb_en, is_load}; REG_ZERO constant; function youngest_match().
//  Sub-module hazard_scoreboard: shift register of sb_entry_t, ports clk/rst/push/push_entry/entries.
//  Match, priority, stall and mux logic plus counters stay in hazard_forward_unit.
// TESTING
//  add r3 (k=0), then ID sub r4,r3,r5 with ex_result=0x11 -> id_stall=0, fwd1_en=1, fwd1_data=0x11.
//  lw r3, then dependent add -> id_stall=1 for 2 cycles, then fwd1_data=stage_data slice 1 (0xCAFE); stall_cnt=2.
//  addi r3; addi r3 back-to-back; then use of r3 -> value from k=0 (younger), not k=1.
//  ID reads r0 with an in-flight write to r0 -> no stall, fwdN_en=0.
//  Load-use hazard with flush=1 in the same cycle -> id_stall=0, bubble pushed into entry 0.
//  HAZARD_FORWARDING_EN undefined, FWD_DEPTH=3: add r3, dependent use -> 3 stall cycles, fwd never set.
//  rst=0 pulse while stalled -> next cycle id_stall=0 and counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller and its in-flight scoreboard.
package hazard_pkg;

  localparam int SB_ADDR_W = 8;   // widest register index the scoreboard can hold
  localparam int MAX_DEPTH = 16;
  localparam int IDX_W     = 4;

  localparam logic [SB_ADDR_W-1:0] REG_ZERO = 8'd0;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] dest;
    logic                 wb_en;
    logic                 is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, dest: 8'd0, wb_en: 1'b0, is_load: 1'b0};

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } match_t;

  // Lowest set bit wins: entry 0 is the youngest producer.
  function automatic match_t youngest_match(input logic [MAX_DEPTH-1:0] hits);
    match_t res;
    res.found = 1'b0;
    res.idx   = 4'd0;
    for (int k = MAX_DEPTH - 1; k >= 0; k--) begin
      if (hits[k]) begin
        res.found = 1'b1;
        res.idx   = k[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations; entry 0 is EX, the last entry is the stage before
// regfile write. Stages past ID never stall, so it advances every cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  output sb_entry_t [DEPTH-1:0] entries
);

  sb_entry_t [DEPTH-1:0] entries_r;

  // Advance the pipeline image; a bubble enters whenever ID does not issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_r <= {DEPTH{SB_BUBBLE}};
    end else begin
      entries_r[0] <= push ? push_entry : SB_BUBBLE;
      for (int k = 1; k < DEPTH; k++) begin
        entries_r[k] <= entries_r[k-1];
      end
    end
  end

  assign entries = entries_r;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for ID, driven by an internal in-flight scoreboard.
// Define HAZARD_FORWARDING_EN to enable forwarding; otherwise every dependency stalls until retire.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_src1,
  input  logic [REG_ADDR_W-1:0]         id_src2,
  input  logic                          id_use_src2,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_mem_r_en,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic [(FWD_DEPTH-1)*DATA_W-1:0] stage_data,
  output logic                          id_stall,
  output logic                          fwd1_en,
  output logic [DATA_W-1:0]             fwd1_data,
  output logic                          fwd2_en,
  output logic [DATA_W-1:0]             fwd2_data,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              fwd_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  sb_entry_t [FWD_DEPTH-1:0] entries_s;
  sb_entry_t                 push_entry_s;
  logic                      push_s;

  logic [SB_ADDR_W-1:0] src1_s;
  logic [SB_ADDR_W-1:0] src2_s;
  logic [MAX_DEPTH-1:0] hits1_s;
  logic [MAX_DEPTH-1:0] hits2_s;
  logic [FWD_DEPTH-1:0] ready_s;
  logic [DATA_W-1:0]    data_s [FWD_DEPTH];

  match_t            y1_s;
  match_t            y2_s;
  logic              rdy1_s;
  logic              rdy2_s;
  logic [DATA_W-1:0] val1_s;
  logic [DATA_W-1:0] val2_s;
  logic              hazard_s;
  logic              fwd1_en_s;
  logic              fwd2_en_s;

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] fwd_cnt_r;

  assign push_s       = id_valid & ~id_stall & ~flush;
  assign push_entry_s = '{valid: 1'b1, dest: SB_ADDR_W'(id_dest), wb_en: id_wb_en, is_load: id_mem_r_en};

  hazard_scoreboard #(
    .DEPTH (FWD_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .entries    (entries_s)
  );

  // Per-entry source matches and data readiness; r0 never creates a dependency.
  always_comb begin
    src1_s  = SB_ADDR_W'(id_src1);
    src2_s  = SB_ADDR_W'(id_src2);
    hits1_s = {MAX_DEPTH{1'b0}};
    hits2_s = {MAX_DEPTH{1'b0}};
    ready_s = {FWD_DEPTH{1'b0}};
    for (int k = 0; k < FWD_DEPTH; k++) begin
      hits1_s[k] = entries_s[k].valid & entries_s[k].wb_en &
                   (entries_s[k].dest == src1_s) & (src1_s != REG_ZERO);
      hits2_s[k] = id_use_src2 & entries_s[k].valid & entries_s[k].wb_en &
                   (entries_s[k].dest == src2_s) & (src2_s != REG_ZERO);
      ready_s[k] = ~entries_s[k].is_load | (k >= LOAD_STAGE);
    end
  end

  // Result visible for each tracked entry: EX is combinational, later stages come from pipeline regs.
  always_comb begin
    data_s[0] = ex_result;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      data_s[k] = stage_data[(k-1)*DATA_W +: DATA_W];
    end
  end

  // Youngest-producer selection for each operand.
  always_comb begin
    y1_s   = youngest_match(hits1_s);
    y2_s   = youngest_match(hits2_s);
    rdy1_s = 1'b0;
    rdy2_s = 1'b0;
    val1_s = {DATA_W{1'b0}};
    val2_s = {DATA_W{1'b0}};
    for (int k = 0; k < FWD_DEPTH; k++) begin
      rdy1_s = (y1_s.idx == IDX_W'(k)) ? ready_s[k] : rdy1_s;
      val1_s = (y1_s.idx == IDX_W'(k)) ? data_s[k]  : val1_s;
      rdy2_s = (y2_s.idx == IDX_W'(k)) ? ready_s[k] : rdy2_s;
      val2_s = (y2_s.idx == IDX_W'(k)) ? data_s[k]  : val2_s;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Stall only while the youngest producer's value is not yet on a forwarding path.
  always_comb begin
    hazard_s  = (y1_s.found & ~rdy1_s) | (y2_s.found & ~rdy2_s);
    fwd1_en_s = id_valid & y1_s.found & rdy1_s;
    fwd2_en_s = id_valid & y2_s.found & rdy2_s;
  end
`else
  logic unused_ready_s;
  assign unused_ready_s = rdy1_s ^ rdy2_s;

  // Without forwarding, any in-flight producer blocks the consumer until it retires.
  always_comb begin
    hazard_s  = y1_s.found | y2_s.found;
    fwd1_en_s = 1'b0;
    fwd2_en_s = 1'b0;
  end
`endif

  assign id_stall  = id_valid & ~flush & hazard_s;
  assign fwd1_en   = fwd1_en_s;
  assign fwd2_en   = fwd2_en_s;
  assign fwd1_data = fwd1_en_s ? val1_s : {DATA_W{1'b0}};
  assign fwd2_data = fwd2_en_s ? val2_s : {DATA_W{1'b0}};

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      fwd_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (id_stall && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if ((fwd1_en_s || fwd2_en_s) && (fwd_cnt_r != CNT_MAX)) begin
        fwd_cnt_r <= fwd_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign fwd_cnt   = fwd_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; expectations cover both HAZARD_FORWARDING_EN builds.
module tb_hazard_forward_unit;

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        f1en;
    logic [31:0] f1d;
    logic        f2en;
    logic [31:0] f2d;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_src1 = 5'd0;
  logic [4:0]  id_src2 = 5'd0;
  logic        id_use_src2 = 1'b0;
  logic [4:0]  id_dest = 5'd0;
  logic        id_wb_en = 1'b0;
  logic        id_mem_r_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ex_result = 32'd0;
  logic [63:0] stage_data = 64'd0;
  logic        id_stall;
  logic        fwd1_en;
  logic [31:0] fwd1_data;
  logic        fwd2_en;
  logic [31:0] fwd2_data;
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    acc_stall = 0;
  int    acc_fwd = 0;

  hazard_forward_unit #(
    .REG_ADDR_W (5),
    .DATA_W     (32),
    .FWD_DEPTH  (3),
    .LOAD_STAGE (2),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src2 (id_use_src2),
    .id_dest     (id_dest),
    .id_wb_en    (id_wb_en),
    .id_mem_r_en (id_mem_r_en),
    .flush       (flush),
    .ex_result   (ex_result),
    .stage_data  (stage_data),
    .id_stall    (id_stall),
    .fwd1_en     (fwd1_en),
    .fwd1_data   (fwd1_data),
    .fwd2_en     (fwd2_en),
    .fwd2_data   (fwd2_data),
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare outputs on the falling edge against queued expectations.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, "id_stall",  32'(id_stall),  32'(e.stall));
        chk(nm, "fwd1_en",   32'(fwd1_en),   32'(e.f1en));
        chk(nm, "fwd1_data", fwd1_data,      e.f1d);
        chk(nm, "fwd2_en",   32'(fwd2_en),   32'(e.f2en));
        chk(nm, "fwd2_data", fwd2_data,      e.f2d);
        chk(nm, "stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        chk(nm, "fwd_cnt",   32'(fwd_cnt),   32'(e.fcnt));
      end
    end
  end

  task automatic push_exp(input string nm, input logic e_st, input logic e_f1, input logic [31:0] e_d1,
                          input logic e_f2, input logic [31:0] e_d2);
    exp_t e;
    e.stall = e_st;
    e.f1en  = e_f1 & FWD_ON;
    e.f1d   = FWD_ON ? e_d1 : 32'd0;
    e.f2en  = e_f2 & FWD_ON;
    e.f2d   = FWD_ON ? e_d2 : 32'd0;
    e.scnt  = 16'(acc_stall);
    e.fcnt  = 16'(acc_fwd);
    acc_stall = acc_stall + (e_st ? 1 : 0);
    acc_fwd   = acc_fwd + ((e.f1en | e.f2en) ? 1 : 0);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic wb, input logic mr, input logic fl,
                       input logic [31:0] ex, input logic [31:0] sd1, input logic [31:0] sd2);
    id_valid = v;   id_src1 = s1;  id_src2 = s2;  id_use_src2 = u2;
    id_dest  = d;   id_wb_en = wb; id_mem_r_en = mr; flush = fl;
    ex_result = ex; stage_data = {sd2, sd1};
  endtask

  task automatic step(input string nm, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic [4:0] d, input logic wb, input logic mr, input logic fl,
                      input logic [31:0] ex, input logic [31:0] sd1, input logic [31:0] sd2,
                      input logic e_st, input logic e_f1, input logic [31:0] e_d1,
                      input logic e_f2, input logic [31:0] e_d2);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(v, s1, s2, u2, d, wb, mr, fl, ex, sd1, sd2);
    push_exp(nm, e_st, e_f1, e_d1, e_f2, e_d2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step("idle", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
           1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Reset asserted mid-cycle while ID holds a dependent read of r3.
  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7);
    acc_stall = 0;
    acc_fwd   = 0;
    push_exp(nm, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    do_reset("reset");

    // add r3 then sub r4,r3,r5: forward ex_result from entry 0.
    step("add_r3", 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < (FWD_ON ? 0 : 3); i++)
      step("sub_wait", 1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33,
           1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("sub_fwd", 1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33,
         1'b0, 1'b1, 32'h11, 1'b0, 32'h0);
    idle(3);

    // lw r3 then dependent add: load data appears at entry 2.
    step("lw_r3", 1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < (FWD_ON ? 2 : 3); i++)
      step("ld_use_wait", 1'b1, 5'd3, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h99, 32'hBEEF, 32'hCAFE,
           1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("ld_use_fwd", 1'b1, 5'd3, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h99, 32'hBEEF, 32'hCAFE,
         1'b0, 1'b1, 32'hCAFE, 1'b0, 32'h0);
    idle(3);

    // Two writers of r3; unused src2 field naming r3 is ignored; youngest value goes to src2.
    step("addi_a", 1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("addi_b", 1'b1, 5'd2, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < (FWD_ON ? 0 : 3); i++)
      step("young_wait", 1'b1, 5'd9, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h44, 32'h55, 32'h66,
           1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("young_fwd", 1'b1, 5'd9, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h44, 32'h55, 32'h66,
         1'b0, 1'b0, 32'h0, 1'b1, 32'h44);
    idle(3);

    // A write to r0 never creates a dependency.
    step("add_r0", 1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("read_r0", 1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(3);

    // Flush beats a load-use hazard; the flushed r10 writer must not enter the scoreboard.
    step("lw_r3_f", 1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("flush_ld_use", 1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("after_flush", 1'b1, 5'd10, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0, 32'h88, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(3);

    // Non-load producer at entry 1 forwards stage_data slice 0.
    step("add_r12", 1'b1, 5'd1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1);
    for (int i = 0; i < (FWD_ON ? 0 : 2); i++)
      step("k1_wait", 1'b1, 5'd12, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 32'hAA, 32'hBB, 32'hCC,
           1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("k1_fwd", 1'b1, 5'd12, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 32'hAA, 32'hBB, 32'hCC,
         1'b0, 1'b1, 32'hBB, 1'b0, 32'h0);
    idle(3);

    // Reset while stalled drops the hazard and clears the counters.
    step("lw_r3_r", 1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall_pre_rst", 1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7,
         1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    do_reset("mid_reset");
    step("post_rst", 1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7,
         1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
